// File: rtl/umni_pkg.sv
// Shared types and constants for the humidity BCD converter.
package umni_pkg;

  localparam int W_SOMA           = 8;
  localparam int N_DIG_BCD        = 3;
  localparam int MAX_UMIDADE_SOMA = 200;

  typedef enum logic [1:0] {
    OCIOSO,
    CONVERTE,
    PRONTO
  } estado_t;

endpackage

// File: rtl/conversor_bcd_umidade_if.sv
// Handshake bus between the sensor adder, the BCD converter and the display stage.
interface conversor_bcd_umidade_if import umni_pkg::*; #(
  parameter int W_IN  = W_SOMA,
  parameter int N_DIG = N_DIG_BCD
);

  logic [W_IN-1:0]    entrada;
  logic               entrada_valida;
  logic               entrada_pronta;
  logic [4*N_DIG-1:0] digitos;
  logic               erro_faixa;
  logic               saida_valida;
  logic               saida_aceita;

  modport master (
    output entrada, entrada_valida, saida_aceita,
    input  entrada_pronta, digitos, erro_faixa, saida_valida
  );

  modport slave (
    input  entrada, entrada_valida, saida_aceita,
    output entrada_pronta, digitos, erro_faixa, saida_valida
  );

endinterface

// File: rtl/ajuste_bcd_digito.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module ajuste_bcd_digito (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = din;
    if (din >= 4'd5) dout = din + 4'd3;
  end

endmodule

// File: rtl/conversor_bcd_umidade.sv
// Serial binary-to-BCD converter for the humidity sum, with clamp and valid/ready handshakes.
// Build option: define MEDIA_EN to convert the rounded mean (sum+1)>>1 instead of the clamped sum.
module conversor_bcd_umidade import umni_pkg::*; #(
  parameter int W_IN   = W_SOMA,
  parameter int N_DIG  = N_DIG_BCD,
  parameter int MAX_IN = MAX_UMIDADE_SOMA
) (
  input  logic                    clock,
  input  logic                    reset_n,
  conversor_bcd_umidade_if.slave  bus
);

  localparam int CW = $clog2(W_IN + 1);
  localparam int BW = 4 * N_DIG;
  localparam logic [W_IN-1:0] MAX_V = W_IN'(MAX_IN);

  estado_t          estado_q, estado_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W_IN-1:0]  v_q, v_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic             erro_conv_q, erro_conv_d;
  logic [BW-1:0]    digitos_q, digitos_d;
  logic             erro_q, erro_d;
  logic             valida_q, valida_d;

  logic             acima;
  logic [W_IN-1:0]  limitado;
  logic [W_IN-1:0]  convertido;
  logic [BW-1:0]    bcd_adj;
  logic [BW+W_IN-1:0] deslocado;

  // Clamp first, then the optional averaging on a one-bit-wider intermediate.
  always_comb begin
    acima    = (bus.entrada > MAX_V);
    limitado = acima ? MAX_V : bus.entrada;
  end

`ifdef MEDIA_EN
  logic [W_IN:0] soma_media;
  always_comb begin
    soma_media = {1'b0, limitado} + (W_IN+1)'(1);
    convertido = soma_media[W_IN:1];
  end
`else
  always_comb convertido = limitado;
`endif

  for (genvar g = 0; g < N_DIG; g++) begin : g_ajuste
    ajuste_bcd_digito u_ajuste (
      .din  (bcd_q[4*g +: 4]),
      .dout (bcd_adj[4*g +: 4])
    );
  end

  always_comb deslocado = {bcd_adj, v_q} << 1;

  always_comb begin
    estado_d    = estado_q;
    cnt_d       = cnt_q;
    v_d         = v_q;
    bcd_d       = bcd_q;
    erro_conv_d = erro_conv_q;
    digitos_d   = digitos_q;
    erro_d      = erro_q;
    valida_d    = valida_q;
    case (estado_q)
      OCIOSO: begin
        if (bus.entrada_valida) begin
          v_d         = convertido;
          erro_conv_d = acima;
          bcd_d       = '0;
          cnt_d       = CW'(W_IN);
          estado_d    = CONVERTE;
        end
      end
      CONVERTE: begin
        bcd_d = deslocado[BW+W_IN-1:W_IN];
        v_d   = deslocado[W_IN-1:0];
        cnt_d = cnt_q - CW'(1);
        // Last shift: publish the freshly shifted digits directly.
        if (cnt_q == CW'(1)) begin
          digitos_d = deslocado[BW+W_IN-1:W_IN];
          erro_d    = erro_conv_q;
          valida_d  = 1'b1;
          estado_d  = PRONTO;
        end
      end
      PRONTO: begin
        if (bus.saida_aceita) begin
          valida_d = 1'b0;
          estado_d = OCIOSO;
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q    <= OCIOSO;
      cnt_q       <= '0;
      v_q         <= '0;
      bcd_q       <= '0;
      erro_conv_q <= 1'b0;
      digitos_q   <= '0;
      erro_q      <= 1'b0;
      valida_q    <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      cnt_q       <= cnt_d;
      v_q         <= v_d;
      bcd_q       <= bcd_d;
      erro_conv_q <= erro_conv_d;
      digitos_q   <= digitos_d;
      erro_q      <= erro_d;
      valida_q    <= valida_d;
    end
  end

  assign bus.entrada_pronta = (estado_q == OCIOSO);
  assign bus.digitos        = digitos_q;
  assign bus.erro_faixa     = erro_q;
  assign bus.saida_valida   = valida_q;

endmodule

// File: tb/tb_conversor_bcd_umidade.sv
// Randomized self-checking bench for conversor_bcd_umidade against a decimal arithmetic model.
module tb_conversor_bcd_umidade;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  conversor_bcd_umidade_if bus ();

  conversor_bcd_umidade dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: clamp, optional rounded mean, then decimal digit packing.
  function automatic int model_digits(input int e);
    int v;
    v = (e > 200) ? 200 : e;
`ifdef MEDIA_EN
    v = (v + 1) / 2;
`endif
    return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pronta();
    int n = 0;
    while (!bus.entrada_pronta && n < 50) begin
      tick();
      n++;
    end
    check("pronta_timeout", int'(bus.entrada_pronta), 1);
  endtask

  // Capture one sum, measure latency and check the result (leaves it in PRONTO).
  task automatic convert(input int e);
    int n = 0;
    wait_pronta();
    bus.entrada        = 8'(e);
    bus.entrada_valida = 1'b1;
    tick();
    bus.entrada_valida = 1'b0;
    do begin
      tick();
      n++;
    end while (!bus.saida_valida && n < 30);
    check($sformatf("lat_%0d", e), n, 8);
    check($sformatf("dig_%0d", e), int'(bus.digitos), model_digits(e));
    check($sformatf("err_%0d", e), int'(bus.erro_faixa), (e > 200) ? 1 : 0);
  endtask

  task automatic accept();
    bus.saida_aceita = 1'b1;
    tick();
    bus.saida_aceita = 1'b0;
    check("valid_drop", int'(bus.saida_valida), 0);
  endtask

  initial begin
    int hold_dig;
    int seen;
    int dir_tbl[8] = '{200, 42, 255, 199, 57, 0, 1, 201};

    bus.entrada        = '0;
    bus.entrada_valida = 1'b0;
    bus.saida_aceita   = 1'b0;
    #12;
    check("rst_dig", int'(bus.digitos), 0);
    check("rst_err", int'(bus.erro_faixa), 0);
    check("rst_vld", int'(bus.saida_valida), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst_pronta", int'(bus.entrada_pronta), 1);

    foreach (dir_tbl[i]) begin
      convert(dir_tbl[i]);
      accept();
    end

    for (int i = 0; i < 30; i++) begin
      convert(int'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 3)) tick();
      accept();
    end

    // Backpressure: result must hold and nothing new may be captured.
    convert(123);
    hold_dig = int'(bus.digitos);
    for (int i = 0; i < 20; i++) begin
      bus.entrada_valida = i[0];
      bus.entrada        = 8'($urandom_range(0, 255));
      tick();
      check("bp_dig", int'(bus.digitos), hold_dig);
      check("bp_pronta", int'(bus.entrada_pronta), 0);
    end
    // Accept with a new sum offered on the same edge: only the return to idle happens.
    bus.entrada_valida = 1'b1;
    bus.saida_aceita   = 1'b1;
    tick();
    bus.entrada_valida = 1'b0;
    bus.saida_aceita   = 1'b0;
    check("acc_same_pronta", int'(bus.entrada_pronta), 1);
    convert(77);
    accept();

    // Reset during the conversion aborts it.
    wait_pronta();
    bus.entrada        = 8'd150;
    bus.entrada_valida = 1'b1;
    tick();
    bus.entrada_valida = 1'b0;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("rstc_dig", int'(bus.digitos), 0);
    check("rstc_err", int'(bus.erro_faixa), 0);
    check("rstc_vld", int'(bus.saida_valida), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.saida_valida) seen = 1;
    end
    check("rstc_no_vld", seen, 0);
    check("rstc_pronta", int'(bus.entrada_pronta), 1);
    convert(99);
    accept();

    // Reset while holding a result discards it.
    convert(255);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstp_vld", int'(bus.saida_valida), 0);
    check("rstp_dig", int'(bus.digitos), 0);
    check("rstp_err", int'(bus.erro_faixa), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rstp_pronta", int'(bus.entrada_pronta), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
